// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counter: register offsets, CTRL bit
// positions, FSM state codes and the byte-lane merge used by the write path.
package timer_counter_pkg;

    localparam logic [31:0] TC_BASE      = 32'h0000_7F00;

    localparam logic [1:0]  TC_CTRL      = 2'b00;
    localparam logic [1:0]  TC_PRESET    = 2'b01;
    localparam logic [1:0]  TC_COUNT     = 2'b10;
    localparam logic [1:0]  TC_RSVD      = 2'b11;

    localparam int          CTRL_EN      = 0;
    localparam int          CTRL_MODE_LO = 1;
    localparam int          CTRL_MODE_HI = 2;
    localparam int          CTRL_IM      = 3;

    localparam logic [1:0]  MODE_ONESHOT = 2'b00;
    localparam logic [1:0]  MODE_RELOAD  = 2'b01;

    localparam logic [1:0]  TC_IDLE      = 2'b00;
    localparam logic [1:0]  TC_LOAD      = 2'b01;
    localparam logic [1:0]  TC_CNT       = 2'b10;
    localparam logic [1:0]  TC_INT       = 2'b11;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of the timer: word address, byte-lane write, combinational read
// data and the interrupt request towards CP0.
interface timer_counter_if;
    logic [29:0] Addr;
    logic        WE;
    logic [3:0]  ByteEn;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, ByteEn, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, ByteEn, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_counter.sv
// 32-bit memory-mapped down-counter with one-shot and auto-reload modes; holds
// CTRL, PRESET and COUNT and raises IRQ when the countdown expires.
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);

    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [1:0]  r_state;
    logic        r_irq_flag;

    logic [1:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic        w_im;
    logic        w_reload_mode;
    logic        w_fsm_clr_en;
    logic        w_irq_set;
    logic        w_irq_clr;
    logic        w_unused_addr;

    // The bridge has already selected the window, so only the word offset matters.
    assign w_off         = bus.Addr[1:0];
    assign w_unused_addr = ^bus.Addr[29:2];

    assign w_wr_ctrl     = bus.WE && (w_off == TC_CTRL);
    assign w_wr_preset   = bus.WE && (w_off == TC_PRESET);

    assign w_en          = r_ctrl[CTRL_EN];
    assign w_im          = r_ctrl[CTRL_IM];
    assign w_reload_mode = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    // Every mode other than auto-reload behaves as one-shot and drops En on expiry.
    assign w_fsm_clr_en  = (r_state == TC_INT) && !w_reload_mode;

    assign w_irq_set     = (r_state == TC_CNT) && w_en && (r_count <= 32'd1);
    assign w_irq_clr     = w_wr_ctrl || ((r_state == TC_INT) && w_reload_mode);

    // CTRL lives entirely in byte lane 0; a CPU write takes priority over the FSM's
    // own clearing of En so software never loses a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_preset <= '0;
        end else begin
            if (w_wr_ctrl) begin
                if (bus.ByteEn[0]) begin
                    r_ctrl <= bus.Din[3:0];
                end
            end else if (w_fsm_clr_en) begin
                r_ctrl[CTRL_EN] <= 1'b0;
            end

            if (w_wr_preset) begin
                r_preset <= byte_merge(r_preset, bus.Din, bus.ByteEn);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch below sees
    // the pre-edge values of r_count, r_state and r_ctrl.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= TC_IDLE;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            case (r_state)
                TC_IDLE: begin
                    if (w_en) begin
                        r_state <= TC_LOAD;
                    end
                end
                TC_LOAD: begin
                    r_count <= r_preset;
                    r_state <= TC_CNT;
                end
                TC_CNT: begin
                    if (!w_en) begin
                        r_state <= TC_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count <= '0;
                        r_state <= TC_INT;
                    end
                end
                TC_INT: begin
                    r_state <= TC_IDLE;
                end
                default: begin
                    r_state <= TC_IDLE;
                end
            endcase

            if (w_irq_set) begin
                r_irq_flag <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

    // NOTE: Dout gets a default before the case so no path leaves it unassigned,
    // which keeps this a pure mux rather than a latch.
    always_comb begin
        bus.Dout = '0;
        case (w_off)
            TC_CTRL:   bus.Dout = {28'd0, r_ctrl};
            TC_PRESET: bus.Dout = r_preset;
            TC_COUNT:  bus.Dout = r_count;
            default:   bus.Dout = '0;
        endcase
    end

    assign bus.IRQ = w_im & r_irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: table of register-access vectors, then
// hand-written countdown, reload, freeze, priority and reset sequences.
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    timer_counter_if bus ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  wr_off;
        logic [3:0]  be;
        logic [31:0] din;
        logic [1:0]  rd_off;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
        bus.Addr   = {28'd0, off};
        bus.WE     = 1'b1;
        bus.ByteEn = be;
        bus.Din    = d;
        tick();
        bus.WE     = 1'b0;
        bus.ByteEn = 4'h0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] off, input logic [31:0] exp);
        bus.Addr = {28'd0, off};
        #1;
        check(name, bus.Dout, exp);
    endtask

    task automatic irq_check(input string name, input logic exp);
        check(name, {31'd0, bus.IRQ}, {31'd0, exp});
    endtask

    task automatic state_check(input string name, input logic [1:0] exp);
        check(name, {30'd0, dut.r_state}, {30'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        bus.Addr   = '0;
        bus.WE     = 1'b0;
        bus.ByteEn = 4'h0;
        bus.Din    = '0;

        //           name            we    off        be     din            rd_off     exp_dout       irq
        vecs[0]  = '{"rst_ctrl",     1'b0, TC_CTRL,   4'h0, 32'h0,         TC_CTRL,   32'h0,         1'b0};
        vecs[1]  = '{"rst_preset",   1'b0, TC_CTRL,   4'h0, 32'h0,         TC_PRESET, 32'h0,         1'b0};
        vecs[2]  = '{"rst_count",    1'b0, TC_CTRL,   4'h0, 32'h0,         TC_COUNT,  32'h0,         1'b0};
        vecs[3]  = '{"rst_rsvd",     1'b0, TC_CTRL,   4'h0, 32'h0,         TC_RSVD,   32'h0,         1'b0};
        vecs[4]  = '{"preset_full",  1'b1, TC_PRESET, 4'hF, 32'h11223344,  TC_PRESET, 32'h11223344,  1'b0};
        vecs[5]  = '{"preset_lane2", 1'b1, TC_PRESET, 4'h4, 32'h00AB0000,  TC_PRESET, 32'h11AB3344,  1'b0};
        vecs[6]  = '{"count_ro",     1'b1, TC_COUNT,  4'hF, 32'hDEADBEEF,  TC_COUNT,  32'h0,         1'b0};
        vecs[7]  = '{"rsvd_wr",      1'b1, TC_RSVD,   4'hF, 32'hFFFFFFFF,  TC_RSVD,   32'h0,         1'b0};
        vecs[8]  = '{"preset_keep",  1'b0, TC_CTRL,   4'h0, 32'h0,         TC_PRESET, 32'h11AB3344,  1'b0};
        vecs[9]  = '{"preset_lane0", 1'b1, TC_PRESET, 4'h1, 32'hCAFEBABE,  TC_PRESET, 32'h11AB33BE,  1'b0};
        vecs[10] = '{"ctrl_hi_lane", 1'b1, TC_CTRL,   4'hE, 32'hFFFFFFF6,  TC_CTRL,   32'h0,         1'b0};
        vecs[11] = '{"ctrl_lane0",   1'b1, TC_CTRL,   4'h1, 32'hFFFFFFF6,  TC_CTRL,   32'h6,         1'b0};
        vecs[12] = '{"ctrl_clear",   1'b1, TC_CTRL,   4'hF, 32'h0,         TC_CTRL,   32'h0,         1'b0};

        repeat (3) tick();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].wr_off, vecs[i].din, vecs[i].be);
            end
            rd_check(vecs[i].name, vecs[i].rd_off, vecs[i].exp_dout);
            irq_check({vecs[i].name, "_irq"}, vecs[i].exp_irq);
            tick();
        end

        // One-shot countdown from 5 with the interrupt unmasked.
        wr(TC_PRESET, 32'd5, 4'hF);
        wr(TC_CTRL, 32'h9, 4'hF);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            rd_check($sformatf("m0_count_%0d", i), TC_COUNT, 32'(5 - i));
            irq_check($sformatf("m0_irq_%0d", i), (i == 5));
            tick();
        end
        irq_check("m0_irq_hold", 1'b1);
        rd_check("m0_ctrl_en_clr", TC_CTRL, 32'h8);
        state_check("m0_idle", TC_IDLE);
        tick();
        tick();
        irq_check("m0_irq_still", 1'b1);
        wr(TC_CTRL, 32'h8, 4'hF);
        irq_check("m0_irq_cleared", 1'b0);
        rd_check("m0_ctrl_after", TC_CTRL, 32'h8);

        // PRESET=1 expires on the first CNT cycle; a CTRL write during INT beats the FSM.
        wr(TC_PRESET, 32'd1, 4'hF);
        wr(TC_CTRL, 32'h9, 4'hF);
        tick();
        tick();
        rd_check("p1_count_load", TC_COUNT, 32'd1);
        tick();
        rd_check("p1_count_zero", TC_COUNT, 32'd0);
        irq_check("p1_irq", 1'b1);
        state_check("p1_int", TC_INT);
        wr(TC_CTRL, 32'h9, 4'hF);
        rd_check("cw_ctrl_kept", TC_CTRL, 32'h9);
        irq_check("cw_irq_cleared", 1'b0);
        state_check("cw_idle", TC_IDLE);
        tick();
        state_check("cw_reload", TC_LOAD);
        wr(TC_CTRL, 32'h0, 4'hF);
        tick();
        state_check("cw_stop", TC_IDLE);

        // Auto-reload from 3: INT, IDLE, LOAD and three CNT cycles (COUNT 3,2,1)
        // make a 6-cycle period, first pulse 5 edges after the enabling write.
        wr(TC_PRESET, 32'd3, 4'hF);
        wr(TC_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            tick();
            irq_check($sformatf("m1_irq_c%0d", k), (k >= 5) && (((k - 5) % 6) == 0));
        end
        rd_check("m1_ctrl_en_kept", TC_CTRL, 32'hB);
        wr(TC_CTRL, 32'h0, 4'hF);
        repeat (3) tick();
        state_check("m1_stop", TC_IDLE);

        // Clearing En mid-count freezes COUNT; re-enabling reloads from PRESET.
        wr(TC_PRESET, 32'd10, 4'hF);
        wr(TC_CTRL, 32'h1, 4'hF);
        repeat (5) tick();
        rd_check("fz_count_7", TC_COUNT, 32'd7);
        wr(TC_CTRL, 32'h0, 4'hF);
        rd_check("fz_count_6", TC_COUNT, 32'd6);
        tick();
        rd_check("fz_held", TC_COUNT, 32'd6);
        state_check("fz_idle", TC_IDLE);
        tick();
        tick();
        rd_check("fz_still", TC_COUNT, 32'd6);
        wr(TC_CTRL, 32'h1, 4'hF);
        tick();
        state_check("fz_load", TC_LOAD);
        tick();
        rd_check("fz_reloaded", TC_COUNT, 32'd10);
        wr(TC_PRESET, 32'd20, 4'hF);
        rd_check("pw_count_runs", TC_COUNT, 32'd9);
        rd_check("pw_preset", TC_PRESET, 32'd20);
        repeat (7) tick();
        rd_check("pw_count_2", TC_COUNT, 32'd2);

        // Reset mid-count.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_check("rc_ctrl", TC_CTRL, 32'h0);
        rd_check("rc_preset", TC_PRESET, 32'h0);
        rd_check("rc_count", TC_COUNT, 32'h0);
        irq_check("rc_irq", 1'b0);
        state_check("rc_idle", TC_IDLE);
        tick();
        state_check("rc_idle_next", TC_IDLE);

        // Reset during INT with the interrupt asserted.
        wr(TC_PRESET, 32'd2, 4'hF);
        wr(TC_CTRL, 32'h9, 4'hF);
        tick();
        tick();
        rd_check("ri_count_2", TC_COUNT, 32'd2);
        tick();
        tick();
        irq_check("ri_irq_up", 1'b1);
        state_check("ri_int", TC_INT);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_check("ri_ctrl", TC_CTRL, 32'h0);
        rd_check("ri_preset", TC_PRESET, 32'h0);
        rd_check("ri_count", TC_COUNT, 32'h0);
        irq_check("ri_irq", 1'b0);
        state_check("ri_idle", TC_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
